// File: rtl/glitch_sweep_sequencer_pkg.sv
// Shared widths and FSM state encoding for the glitch sweep sequencer.
package glitch_pkg;

   localparam int DELAY_W = 16;
   localparam int WIDTH_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FIRE      = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_WAIT_FALL = 3'd3,
      ST_GAP       = 3'd4,
      ST_STEP      = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

endpackage

// File: rtl/glitch_sweep_sequencer_sweep_axis.sv
// One sweep dimension: latches start/step/count on load, walks value and index on advance.
// The index is kept apart from the value so value wrap-around never changes the point count.
module sweep_axis #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         advance_i,
   input  logic [W-1:0] start_i,
   input  logic [W-1:0] step_i,
   input  logic [W-1:0] count_i,
   output logic [W-1:0] value_o,
   output logic [W-1:0] index_o,
   output logic         last_o
);

   logic [W-1:0] start_q, start_d;
   logic [W-1:0] step_q, step_d;
   logic [W-1:0] last_idx_q, last_idx_d;
   logic [W-1:0] value_q, value_d;
   logic [W-1:0] index_q, index_d;

   always_comb begin
      start_d    = start_q;
      step_d     = step_q;
      last_idx_d = last_idx_q;
      value_d    = value_q;
      index_d    = index_q;
      if (load_i) begin
         start_d    = start_i;
         step_d     = step_i;
         // A count of zero behaves as a single point
         last_idx_d = (count_i == '0) ? '0 : count_i - W'(1);
         value_d    = start_i;
         index_d    = '0;
      end else if (advance_i) begin
         if (index_q == last_idx_q) begin
            value_d = start_q;
            index_d = '0;
         end else begin
            value_d = value_q + step_q;
            index_d = index_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q    <= '0;
         step_q     <= '0;
         last_idx_q <= '0;
         value_q    <= '0;
         index_q    <= '0;
      end else begin
         start_q    <= start_d;
         step_q     <= step_d;
         last_idx_q <= last_idx_d;
         value_q    <= value_d;
         index_q    <= index_d;
      end
   end

   assign value_o = value_q;
   assign index_o = index_q;
   assign last_o  = (index_q == last_idx_q);

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// 2-D delay x width sweep driver for glitch_control (width inner loop, delay outer loop).
// Define SWEEP_FAULT_STOP_EN to end the sweep early when fault_i is seen after a glitch.
module glitch_sweep_sequencer
   import glitch_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 16,
   parameter int ATTEMPT_W    = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [DELAY_W-1:0]   delay_start_i,
   input  logic [DELAY_W-1:0]   delay_step_i,
   input  logic [DELAY_W-1:0]   delay_count_i,
   input  logic [WIDTH_W-1:0]   width_start_i,
   input  logic [WIDTH_W-1:0]   width_step_i,
   input  logic [WIDTH_W-1:0]   width_count_i,
   input  logic [15:0]          gap_i,
   input  logic                 glitch_busy_i,
   input  logic                 fault_i,
   output logic                 fire_o,
   output logic [DELAY_W-1:0]   delay_o,
   output logic [WIDTH_W-1:0]   width_o,
   output logic [ATTEMPT_W-1:0] attempt_cnt_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 fault_hit_o
);

   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [15:0]          gap_cfg_q, gap_cfg_d;
   logic [15:0]          gap_cnt_q, gap_cnt_d;
   logic [ATTEMPT_W-1:0] attempt_q, attempt_d;
   logic                 abort_pend_q, abort_pend_d;
   logic                 fault_hit_q, fault_hit_d;

   logic                 axis_load;
   logic                 step_go;
   logic                 fault_stop;
   logic                 delay_last, width_last;
   logic [DELAY_W-1:0]   delay_idx_unused;
   logic [WIDTH_W-1:0]   width_idx_unused;

`ifdef SWEEP_FAULT_STOP_EN
   assign fault_stop = fault_i && (state_q == ST_WAIT_FALL || state_q == ST_GAP);
`else
   logic fault_unused;
   assign fault_unused = fault_i;
   assign fault_stop   = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      gap_cfg_d    = gap_cfg_q;
      gap_cnt_d    = gap_cnt_q;
      attempt_d    = attempt_q;
      abort_pend_d = abort_pend_q | (abort_i && state_q != ST_IDLE);
      fault_hit_d  = fault_hit_q;
      axis_load    = 1'b0;
      step_go      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d      = ST_FIRE;
               axis_load    = 1'b1;
               gap_cfg_d    = gap_i;
               attempt_d    = '0;
               abort_pend_d = 1'b0;
               fault_hit_d  = 1'b0;
            end
         end
         ST_FIRE: begin
            if (attempt_q != '1) attempt_d = attempt_q + ATTEMPT_W'(1);
            timer_d   = '0;
            gap_cnt_d = '0;
            state_d   = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            // A glitch that never answers still counts as an attempt; move on without retry
            if (glitch_busy_i)          state_d = ST_WAIT_FALL;
            else if (timer_q == TMR_LAST) state_d = ST_GAP;
            else                        timer_d = timer_q + TMR_W'(1);
         end
         ST_WAIT_FALL: begin
            if (fault_stop) begin
               fault_hit_d = 1'b1;
               state_d     = ST_DONE;
            end else if (!glitch_busy_i) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (fault_stop) begin
               fault_hit_d = 1'b1;
               state_d     = ST_DONE;
            end else if (gap_cfg_q == '0 || gap_cnt_q == gap_cfg_q - 16'd1) begin
               state_d = ST_STEP;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         ST_STEP: begin
            if (abort_pend_q || abort_i || (delay_last && width_last)) begin
               state_d = ST_DONE;
            end else begin
               step_go = 1'b1;
               state_d = ST_FIRE;
            end
         end
         ST_DONE: begin
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         gap_cfg_q    <= '0;
         gap_cnt_q    <= '0;
         attempt_q    <= '0;
         abort_pend_q <= 1'b0;
         fault_hit_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         gap_cfg_q    <= gap_cfg_d;
         gap_cnt_q    <= gap_cnt_d;
         attempt_q    <= attempt_d;
         abort_pend_q <= abort_pend_d;
         fault_hit_q  <= fault_hit_d;
      end
   end

   sweep_axis #(.W(DELAY_W)) u_delay_axis (
      .clk       (clk),
      .rst       (rst),
      .load_i    (axis_load),
      .advance_i (step_go && width_last),
      .start_i   (delay_start_i),
      .step_i    (delay_step_i),
      .count_i   (delay_count_i),
      .value_o   (delay_o),
      .index_o   (delay_idx_unused),
      .last_o    (delay_last)
   );

   sweep_axis #(.W(WIDTH_W)) u_width_axis (
      .clk       (clk),
      .rst       (rst),
      .load_i    (axis_load),
      .advance_i (step_go),
      .start_i   (width_start_i),
      .step_i    (width_step_i),
      .count_i   (width_count_i),
      .value_o   (width_o),
      .index_o   (width_idx_unused),
      .last_o    (width_last)
   );

   assign fire_o        = (state_q == ST_FIRE);
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = (state_q == ST_DONE);
   assign attempt_cnt_o = attempt_q;
   assign fault_hit_o   = fault_hit_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Bench for glitch_sweep_sequencer: vector table, reset/wrap sequence and random sweeps
// checked against a point-list model with a simple glitch_control busy responder.
module tb_glitch_sweep_sequencer;

   localparam int BUSY_TIMEOUT = 16;
`ifdef SWEEP_FAULT_STOP_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0, abort_i = 1'b0, glitch_busy_i = 1'b0, fault_i = 1'b0;
   logic [15:0] delay_start_i = '0, delay_step_i = '0, delay_count_i = '0, gap_i = '0;
   logic [7:0]  width_start_i = '0, width_step_i = '0, width_count_i = '0;
   logic        fire_o, busy_o, done_o, fault_hit_o;
   logic [15:0] delay_o;
   logic [7:0]  width_o;
   logic [23:0] attempt_cnt_o;

   glitch_sweep_sequencer #(.BUSY_TIMEOUT(BUSY_TIMEOUT), .ATTEMPT_W(24)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .delay_start_i (delay_start_i),
      .delay_step_i  (delay_step_i),
      .delay_count_i (delay_count_i),
      .width_start_i (width_start_i),
      .width_step_i  (width_step_i),
      .width_count_i (width_count_i),
      .gap_i         (gap_i),
      .glitch_busy_i (glitch_busy_i),
      .fault_i       (fault_i),
      .fire_o        (fire_o),
      .delay_o       (delay_o),
      .width_o       (width_o),
      .attempt_cnt_o (attempt_cnt_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .fault_hit_o   (fault_hit_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [15:0] ds, dstep, dc;
      logic [7:0]  ws, wstep, wc;
      logic [15:0] gap;
      int          busy_len;
      bit          no_busy;
      int          abort_at;
      int          fault_at;
      bit          disturb;
      int          exp_n;
      logic [15:0] exp_ld;
      logic [7:0]  exp_lw;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [15:0] fire_d[$];
   logic [7:0]  fire_w[$];
   int          done_cnt = 0;
   int          last_fall_cyc = -1;
   int          last_fire_cyc = -1;
   int          busy_len_cfg = 4;
   bit          no_busy_cfg = 1'b0;
   int          exp_lat = 3;
   int          exp_period = 19;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // glitch_control stand-in: busy rises the cycle after fire_o and stays high busy_len cycles
   initial forever begin
      @(negedge clk);
      if (fire_o && !rst && !no_busy_cfg) begin
         @(negedge clk);
         glitch_busy_i = 1'b1;
         repeat (busy_len_cfg) @(negedge clk);
         glitch_busy_i = 1'b0;
         last_fall_cyc = cyc;
      end
   end

   // Monitor: logs every fired point and checks the cycle spacing rules
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (fire_o) begin
            fire_d.push_back(delay_o);
            fire_w.push_back(width_o);
            if (last_fall_cyc >= 0)
               check("fall_to_fire", cyc - last_fall_cyc, exp_lat);
            else if (no_busy_cfg && last_fire_cyc >= 0)
               check("timeout_fire_period", cyc - last_fire_cyc, exp_period);
            last_fall_cyc = -1;
            last_fire_cyc = cyc;
         end
         if (done_o) begin
            done_cnt++;
            if (last_fall_cyc >= 0)
               check("fall_to_done", cyc - last_fall_cyc, exp_lat);
            else if (no_busy_cfg && last_fire_cyc >= 0)
               check("timeout_done_period", cyc - last_fire_cyc, exp_period);
         end
      end
   end

   task automatic run_sweep(input vec_t v, input string tag);
      int nd, nw, total, exp_n, g, n, limit, i, j;
      int unsigned tmp;
      bit a_done, f_done, s_done;
      logic [15:0] ed;
      logic [7:0]  ew;
      nd    = (v.dc == 0) ? 1 : int'(v.dc);
      nw    = (v.wc == 0) ? 1 : int'(v.wc);
      total = nd * nw;
      exp_n = (v.abort_at > 0) ? v.abort_at : ((FAULT_EN && v.fault_at > 0) ? v.fault_at : total);
      g     = (v.gap == 0) ? 1 : int'(v.gap);
      busy_len_cfg  = v.busy_len;
      no_busy_cfg   = v.no_busy;
      exp_lat       = g + 2;
      exp_period    = BUSY_TIMEOUT + 2 + g;
      fire_d.delete();
      fire_w.delete();
      done_cnt      = 0;
      last_fall_cyc = -1;
      last_fire_cyc = -1;

      delay_start_i = v.ds;  delay_step_i = v.dstep; delay_count_i = v.dc;
      width_start_i = v.ws;  width_step_i = v.wstep; width_count_i = v.wc;
      gap_i = v.gap;
      start_i = 1'b1;
      abort_i = v.disturb;
      @(negedge clk);
      check({tag, "_start_to_fire"}, fire_o, 1'b1);
      start_i = 1'b0;
      abort_i = 1'b0;
      if (v.disturb) begin
         delay_start_i = 16'($urandom); delay_step_i = 16'($urandom); delay_count_i = 16'($urandom);
         width_start_i = 8'($urandom);  width_step_i = 8'($urandom);  width_count_i = 8'($urandom);
         gap_i = 16'($urandom);
      end

      limit = total * (v.busy_len + g + 30) + 50;
      n = 0; a_done = 0; f_done = 0; s_done = 0;
      while (done_cnt == 0 && n < limit) begin
         @(negedge clk);
         n++;
         start_i = 1'b0; abort_i = 1'b0; fault_i = 1'b0;
         if (v.abort_at > 0 && !a_done && fire_d.size() == v.abort_at && glitch_busy_i) begin
            abort_i = 1'b1; a_done = 1;
         end
         if (v.fault_at > 0 && !f_done && fire_d.size() == v.fault_at && glitch_busy_i) begin
            fault_i = 1'b1; f_done = 1;
         end
         if (v.disturb && !s_done && fire_d.size() >= 1 && busy_o && !done_o) begin
            start_i = 1'b1; s_done = 1;
         end
      end
      start_i = 1'b0; abort_i = 1'b0; fault_i = 1'b0;
      if (n >= limit) check({tag, "_done_within_budget"}, 0, 1);

      n = 0;
      while (glitch_busy_i && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);

      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_busy_after"}, busy_o, 1'b0);
      check({tag, "_fire_count"}, fire_d.size(), exp_n);
      check({tag, "_attempt_cnt"}, attempt_cnt_o, exp_n);
      check({tag, "_fault_hit"}, fault_hit_o, (FAULT_EN && v.fault_at > 0));
      for (int k = 0; k < fire_d.size() && k < exp_n; k++) begin
         i   = k / nw;
         j   = k % nw;
         tmp = int'(v.ds) + i * int'(v.dstep);
         ed  = tmp[15:0];
         tmp = int'(v.ws) + j * int'(v.wstep);
         ew  = tmp[7:0];
         check({tag, "_pt_delay"}, fire_d[k], ed);
         check({tag, "_pt_width"}, fire_w[k], ew);
         if (k == exp_n - 1) begin
            check({tag, "_final_delay_o"}, delay_o, ed);
            check({tag, "_final_width_o"}, width_o, ew);
         end
      end
   endtask

   vec_t tbl[6];
   vec_t rv;
   int   n_wait;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_fire", fire_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_done", done_o, 1'b0);
      check("reset_delay", delay_o, 16'd0);
      check("reset_width", width_o, 8'd0);
      check("reset_attempt", attempt_cnt_o, 24'd0);
      check("reset_fault_hit", fault_hit_o, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      //         ds      dstep   dc     ws      wstep  wc     gap    busy nb  abt flt dis  n  last_d last_w
      tbl[0] = '{16'd100, 16'd10, 16'd3, 8'd5,   8'd2,  8'd2, 16'd4, 20, 1'b0, 0, 0, 1'b0, 6, 16'd120, 8'd7};
      tbl[1] = '{16'd7,   16'd3,  16'd0, 8'd9,   8'd3,  8'd0, 16'd2, 5,  1'b0, 0, 0, 1'b0, 1, 16'd7,   8'd9};
      tbl[2] = '{16'd1,   16'd1,  16'd2, 8'd1,   8'd1,  8'd2, 16'd1, 3,  1'b1, 0, 0, 1'b0, 4, 16'd2,   8'd2};
      tbl[3] = '{16'd0,   16'd5,  16'd3, 8'd0,   8'd1,  8'd3, 16'd2, 6,  1'b0, 2, 0, 1'b0, 2, 16'd0,   8'd1};
      tbl[4] = '{16'd50,  16'd0,  16'd1, 8'd250, 8'd10, 8'd2, 16'd3, 3,  1'b0, 0, 0, 1'b1, 2, 16'd50,  8'd4};
      tbl[5] = '{16'd10,  16'd10, 16'd2, 8'd1,   8'd1,  8'd3, 16'd0, 6,  1'b0, 0, 4, 1'b0,
                 FAULT_EN ? 4 : 6, 16'd20, FAULT_EN ? 8'd1 : 8'd3};

      for (int t = 0; t < 6; t++) begin
         run_sweep(tbl[t], $sformatf("vec%0d", t));
         check($sformatf("vec%0d_tbl_attempts", t), fire_d.size(), tbl[t].exp_n);
         check($sformatf("vec%0d_tbl_last_delay", t), (fire_d.size() > 0) ? fire_d[$] : 16'hxxxx, tbl[t].exp_ld);
         check($sformatf("vec%0d_tbl_last_width", t), (fire_w.size() > 0) ? fire_w[$] : 8'hxx, tbl[t].exp_lw);
      end

      // Reset asserted mid-GAP must clear every output before the next clock edge
      busy_len_cfg = 3; no_busy_cfg = 1'b0; exp_lat = 12;
      fire_d.delete(); fire_w.delete(); last_fall_cyc = -1; last_fire_cyc = -1;
      delay_start_i = 16'd3; delay_step_i = 16'd1; delay_count_i = 16'd1;
      width_start_i = 8'd250; width_step_i = 8'd10; width_count_i = 8'd2; gap_i = 16'd10;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n_wait = 0;
      while (last_fall_cyc < 0 && n_wait < 100) begin
         @(negedge clk);
         n_wait++;
      end
      check("rstgap_busy_fell", n_wait < 100, 1'b1);
      repeat (2) @(negedge clk);
      check("rstgap_pre_width", width_o, 8'd250);
      check("rstgap_pre_attempt", attempt_cnt_o, 24'd1);
      check("rstgap_pre_busy", busy_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstgap_fire", fire_o, 1'b0);
      check("rstgap_busy", busy_o, 1'b0);
      check("rstgap_done", done_o, 1'b0);
      check("rstgap_delay", delay_o, 16'd0);
      check("rstgap_width", width_o, 8'd0);
      check("rstgap_attempt", attempt_cnt_o, 24'd0);
      check("rstgap_fault_hit", fault_hit_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rstgap_stays_idle", busy_o, 1'b0);

      for (int r = 0; r < 20; r++) begin
         rv.ds = 16'($urandom); rv.dstep = 16'($urandom); rv.dc = 16'($urandom_range(0, 4));
         rv.ws = 8'($urandom);  rv.wstep = 8'($urandom);  rv.wc = 8'($urandom_range(0, 4));
         rv.gap      = 16'($urandom_range(0, 5));
         rv.busy_len = $urandom_range(1, 6);
         rv.no_busy  = ($urandom_range(0, 4) == 0);
         rv.disturb  = $urandom_range(0, 1);
         rv.fault_at = 0;
         rv.abort_at = 0;
         if (!rv.no_busy && (rv.dc > 1 || rv.wc > 1) && $urandom_range(0, 3) == 0)
            rv.abort_at = 1;
         rv.exp_n = 0; rv.exp_ld = '0; rv.exp_lw = '0;
         abort_i = 1'b1;
         @(negedge clk);
         abort_i = 1'b0;
         run_sweep(rv, $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
